// File: rtl/sa_ctrl.sv
// Host-side sequencer for sa_top: loads B, streams A, waits for the drain, requests C,
// then replays the buffered C rows on a valid/ready output stream.
module sa_ctrl #(
  parameter int WIDTH   = 16,
  parameter int SIZE    = 4,
  parameter int DRAIN   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_vld,
  output logic                  s_rdy,
  input  logic [SIZE*WIDTH-1:0] s_row,
  output logic                  m_vld,
  input  logic                  m_rdy,
  output logic [SIZE*WIDTH-1:0] m_row,
  output logic                  m_last,
  output logic                  o_err,
  output logic                  sa_we,
  output logic                  sa_a_vld,
  output logic [SIZE*WIDTH-1:0] sa_rows,
  output logic                  sa_c_vld,
  input  logic                  sa_c_vld_in,
  input  logic [SIZE*WIDTH-1:0] sa_c_rows
);

  localparam int RW   = SIZE * WIDTH;
  localparam int PW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int CMAX = (DRAIN > SIZE) ? DRAIN : SIZE;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);

  localparam logic [CW-1:0] ROW_LAST   = CW'(SIZE - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN - 1);
  localparam logic [TW-1:0] REQ_LAST   = TW'(SIZE - 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_LAST   = PW'(SIZE - 1);

  typedef enum logic [2:0] {
    ST_ALIGN, ST_LOAD_B, ST_LOAD_A, ST_DRAIN, ST_REQ, ST_COLLECT, ST_OUT, ST_IDLE_ERR
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   tmo;
  logic [PW-1:0]   we_ptr;
  logic [PW-1:0]   ptr_eff;
  logic            cnt_inc;
  logic            hs;
  logic            beat;
  logic [RW-1:0]   cbuf [SIZE];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  assign hs      = s_vld && s_rdy;
  assign beat    = m_vld && m_rdy;
  // Pointer value once the write already in flight has landed.
  assign ptr_eff = sa_we ? ptr_inc(we_ptr) : we_ptr;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_ALIGN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_ALIGN:    if (ptr_eff == '0) state_nxt = ST_LOAD_B;
      ST_LOAD_B:   if (hs && cnt == ROW_LAST) state_nxt = ST_LOAD_A;
      ST_LOAD_A:   if (hs && cnt == ROW_LAST) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (cnt == DRAIN_LAST) state_nxt = ST_REQ;
      ST_REQ:      if (tmo == REQ_LAST) state_nxt = ST_COLLECT;
      ST_COLLECT: begin
        if (sa_c_vld_in && cnt == ROW_LAST) state_nxt = ST_OUT;
        else if (tmo == TMO_LAST)           state_nxt = ST_IDLE_ERR;
      end
      ST_OUT:      if (beat && cnt == ROW_LAST) state_nxt = ST_LOAD_B;
      ST_IDLE_ERR: state_nxt = ST_IDLE_ERR;
      default:     state_nxt = ST_ALIGN;
    endcase
  end

  always_comb begin
    s_rdy  = 1'b0;
    m_vld  = 1'b0;
    m_last = 1'b0;
    m_row  = '0;
    unique case (state)
      ST_LOAD_B, ST_LOAD_A: s_rdy = 1'b1;
      ST_OUT: begin
        m_vld  = 1'b1;
        m_row  = cbuf[cnt[PW-1:0]];
        m_last = (cnt == ROW_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_inc = 1'b0;
    unique case (state)
      ST_LOAD_B, ST_LOAD_A: cnt_inc = hs;
      ST_DRAIN:             cnt_inc = 1'b1;
      ST_COLLECT:           cnt_inc = sa_c_vld_in;
      ST_OUT:               cnt_inc = beat;
      default:              cnt_inc = 1'b0;
    endcase
  end

  // One counter serves rows, drain cycles, C captures and read index; the
  // timeout counter also times the REQ burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      tmo <= '0;
    end else begin
      if (state_nxt != state) cnt <= '0;
      else if (cnt_inc)       cnt <= cnt + CW'(1);
      if (state == ST_REQ || state == ST_COLLECT) tmo <= tmo + TW'(1);
      else                                        tmo <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ST_COLLECT && sa_c_vld_in) cbuf[cnt[PW-1:0]] <= sa_c_rows;
  end

  // Tracks sa_top's reset-less write pointer, so it must survive rst; it relies
  // on the same power-on clear as the array's own pointer.
  always_ff @(posedge clk) begin
    if (sa_we) we_ptr <= ptr_inc(we_ptr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sa_we    <= 1'b0;
      sa_a_vld <= 1'b0;
      sa_c_vld <= 1'b0;
      sa_rows  <= '0;
      o_err    <= 1'b0;
    end else begin
      sa_we    <= (state == ST_ALIGN && ptr_eff != '0) || (state == ST_LOAD_B && hs);
      sa_a_vld <= (state == ST_LOAD_A) && hs;
      sa_c_vld <= (state_nxt == ST_REQ);
      sa_rows  <= hs ? s_row : '0;
      if (state == ST_COLLECT && state_nxt == ST_IDLE_ERR) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sa_ctrl.sv
// Bench for sa_ctrl: plays sa_top (reset-less B store, C = A x B responder) and
// checks output rows, strobe counts, timing, ALIGN padding and timeout.
module tb_sa_ctrl;
  localparam int WIDTH   = 16;
  localparam int SIZE    = 4;
  localparam int DRAIN   = 8;
  localparam int TIMEOUT = 64;
  localparam int RW      = SIZE * WIDTH;
  typedef logic [RW-1:0] row_t;

  logic clk = 1'b0, rst = 1'b1, s_vld = 1'b0, m_rdy = 1'b0, sa_c_vld_in = 1'b0;
  row_t s_row = '0, sa_c_rows = '0;
  logic s_rdy, m_vld, m_last, o_err, sa_we, sa_a_vld, sa_c_vld;
  row_t m_row, sa_rows;

  int checks = 0, errors = 0;

  row_t bmem [SIZE];
  row_t aq[$], rq[$];
  row_t a_tmp, hs_row;
  int   wp = 0, creq = 0, lat = 0, cyc = 0;
  int   we_pulses = 0, a_pulses = 0, pad_cnt = 0, pad_bad = 0, strobe_bad = 0;
  int   last_a_cyc = 0, first_c_cyc = 0, c_run = 0;
  bit   junk = 0, resp_en = 1, resp_gaps = 0, hs_prev = 0;

  row_t jb [SIZE];
  row_t ja [SIZE];

  always #5 clk = ~clk;

  sa_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .s_vld(s_vld), .s_rdy(s_rdy), .s_row(s_row),
    .m_vld(m_vld), .m_rdy(m_rdy), .m_row(m_row), .m_last(m_last), .o_err(o_err),
    .sa_we(sa_we), .sa_a_vld(sa_a_vld), .sa_rows(sa_rows), .sa_c_vld(sa_c_vld),
    .sa_c_vld_in(sa_c_vld_in), .sa_c_rows(sa_c_rows)
  );

  function automatic logic [WIDTH-1:0] el(input row_t r, input int i);
    return r[i*WIDTH +: WIDTH];
  endfunction

  // Row of C = (row of A) x B, every element truncated to WIDTH.
  function automatic row_t mulrow(input row_t a, input row_t b [SIZE]);
    row_t c = '0;
    for (int j = 0; j < SIZE; j++) begin
      logic [WIDTH-1:0] acc = '0;
      for (int k = 0; k < SIZE; k++) acc = acc + el(a, k) * el(b[k], j);
      c[j*WIDTH +: WIDTH] = acc;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input row_t obs, input row_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // sa_top stand-in, sampled 1 time unit before each rising edge.
  initial begin
    forever begin
      @(negedge clk); #4;
      cyc++;
      if (sa_we) begin
        bmem[wp] = sa_rows;
        wp = (wp + 1) % SIZE;
        we_pulses++;
        if (!hs_prev) begin
          pad_cnt++;
          if (sa_rows != '0) pad_bad++;
        end
      end
      if (hs_prev && (sa_we == sa_a_vld)) strobe_bad++;
      if (hs_prev && sa_rows != hs_row) strobe_bad++;
      if (!hs_prev && sa_a_vld) strobe_bad++;
      if (sa_a_vld) begin
        aq.push_back(sa_rows);
        a_pulses++;
        last_a_cyc = cyc;
      end
      if (sa_c_vld) begin
        if (creq == 0) first_c_cyc = cyc;
        creq++;
      end else if (creq > 0) begin
        c_run = creq;
        creq = 0;
        for (int i = 0; i < SIZE; i++) begin
          if (aq.size() > 0) begin
            a_tmp = aq.pop_front();
            if (resp_en) rq.push_back(mulrow(a_tmp, bmem));
          end
        end
        lat  = $urandom_range(0, 3);
        junk = resp_en;
      end
      sa_c_vld_in = 1'b0;
      sa_c_rows   = {$urandom, $urandom};
      if (rst) begin
        rq.delete(); aq.delete(); creq = 0; junk = 0;
      end else if (sa_c_vld && creq == 1 && resp_en) begin
        sa_c_vld_in = 1'b1;
      end else if (rq.size() > 0) begin
        if (lat > 0) lat--;
        else if (!resp_gaps || $urandom_range(0, 3) != 0) begin
          sa_c_vld_in = 1'b1;
          sa_c_rows   = rq.pop_front();
        end
      end else if (junk) begin
        sa_c_vld_in = 1'b1;
        sa_c_rows   = '1;
        junk        = 0;
      end
      hs_prev = s_vld && s_rdy && !rst;
      hs_row  = s_row;
    end
  end

  task automatic send_row(input row_t r, input int gap);
    int n = 0;
    s_vld = 1'b0;
    repeat (gap) @(negedge clk);
    s_vld = 1'b1;
    s_row = r;
    while (!s_rdy && n < 300) begin @(negedge clk); n++; end
    chk("s_rdy_wait", s_rdy, 1);
    @(negedge clk);
    s_vld = 1'b0;
    s_row = {$urandom, $urandom};
  endtask

  task automatic send_all(input int gap_mode);
    for (int r = 0; r < 2 * SIZE; r++) begin
      int g = 0;
      if (gap_mode == 1 && r < SIZE) g = (r == 1) ? 2 : ((r == 3) ? 1 : 0);
      if (gap_mode == 2) g = $urandom_range(0, 2);
      send_row((r < SIZE) ? jb[r] : ja[r - SIZE], g);
    end
  endtask

  task automatic recv_job(input int bp_beat, input bit rnd_rdy);
    for (int b = 0; b < SIZE; b++) begin
      row_t e = mulrow(ja[b], jb);
      int n = 0, hold;
      while (!m_vld && n < 300) begin @(negedge clk); n++; end
      chk("m_vld_wait", m_vld, 1);
      chk("s_rdy_during_out", s_rdy, 0);
      chk("m_row", m_row, e);
      chk("m_last", m_last, (b == SIZE - 1));
      hold = (b == bp_beat) ? 5 : (rnd_rdy ? $urandom_range(0, 2) : 0);
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        chk("m_vld_hold", m_vld, 1);
        chk("m_row_hold", m_row, e);
        chk("s_rdy_hold", s_rdy, 0);
      end
      m_rdy = 1'b1;
      @(negedge clk);
      m_rdy = 1'b0;
    end
  endtask

  task automatic run_job(input int gap_mode, input int bp_beat, input bit rnd_rdy);
    int we0 = we_pulses, a0 = a_pulses;
    send_all(gap_mode);
    recv_job(bp_beat, rnd_rdy);
    chk("we_pulses", we_pulses - we0, SIZE);
    chk("a_pulses", a_pulses - a0, SIZE);
    chk("drain_gap", first_c_cyc - last_a_cyc, DRAIN);
    chk("c_vld_run", c_run, SIZE);
    chk("strobe_bad", strobe_bad, 0);
  endtask

  task automatic rand_job();
    for (int r = 0; r < SIZE; r++) begin
      jb[r] = {$urandom, $urandom};
      ja[r] = {$urandom, $urandom};
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, pads, quiet_bad;
    repeat (3) @(negedge clk);
    chk("rst_s_rdy", s_rdy, 0);
    chk("rst_m_vld", m_vld, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_o_err", o_err, 0);
    chk("rst_sa_we", sa_we, 0);
    chk("rst_sa_a_vld", sa_a_vld, 0);
    chk("rst_sa_c_vld", sa_c_vld, 0);
    chk("rst_sa_rows", sa_rows, 0);
    rst = 1'b0;

    // Identity B: C rows reproduce A.
    for (int r = 0; r < SIZE; r++) begin
      jb[r] = '0;
      jb[r][r*WIDTH +: WIDTH] = 1;
      for (int i = 0; i < SIZE; i++) ja[r][i*WIDTH +: WIDTH] = WIDTH'(r * SIZE + i + 1);
    end
    run_job(0, -1, 0);
    send_all(1);
    recv_job(-1, 0);
    chk("gap_we_total", we_pulses, 2 * SIZE);
    rand_job();
    run_job(0, 1, 0);

    // Reset after two B rows: ALIGN must pad the array pointer back to 0.
    rand_job();
    send_row(jb[0], 0);
    send_row(jb[1], 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_s_rdy", s_rdy, 0);
    pads = 0;
    n = 0;
    while (!s_rdy && n < 20) begin
      @(negedge clk);
      if (sa_we) begin
        pads++;
        chk("pad_rows", sa_rows, 0);
      end
      n++;
    end
    chk("pad_count", pads, 2);
    chk("pad_bad", pad_bad, 0);
    rand_job();
    run_job(0, -1, 0);

    // Timeout: no C rows ever come back.
    resp_en = 0;
    rand_job();
    send_all(0);
    n = 0;
    while (!sa_c_vld && n < 100) begin @(negedge clk); n++; end
    chk("tmo_req_seen", sa_c_vld, 1);
    n = 0;
    quiet_bad = 0;
    while (!o_err && n < 200) begin
      if (s_rdy || m_vld) quiet_bad++;
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, TIMEOUT);
    chk("tmo_quiet", quiet_bad, 0);
    repeat (5) @(negedge clk);
    chk("err_sticky", o_err, 1);
    chk("err_s_rdy", s_rdy, 0);
    chk("err_m_vld", m_vld, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("err_cleared", o_err, 0);
    resp_en = 1;

    // Back-to-back jobs.
    rand_job();
    run_job(0, -1, 0);
    chk("b2b_s_rdy", s_rdy, 1);
    rand_job();
    run_job(0, -1, 0);

    resp_gaps = 1;
    for (int j = 0; j < 4; j++) begin
      rand_job();
      run_job(2, -1, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_ctrl.md
Name: sa_ctrl

Overview:
- Host-side sequencer that drives sa_top as its initiator.
- Accepts a job as a valid/ready stream of 2*SIZE rows: SIZE rows of B, then SIZE rows of A.
- Writes B into the array with sa_we, streams A with sa_a_vld, waits for the array to drain, then requests C with sa_c_vld.
- Captures the SIZE returned C rows into a local buffer and presents them on a valid/ready output stream, row 0 first.

Parameters:
WIDTH, 16, element width in bits (matches sa_top WIDTH)
SIZE, 4, array dimension; rows per matrix
DRAIN, 8, idle cycles between last A row and first sa_c_vld
TIMEOUT, 64, max cycles waiting for C rows before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_vld  in  1  input row valid
s_rdy  out  1  input row ready
s_row  in  SIZE*WIDTH  input row (B rows then A rows), element i at bits [i*WIDTH +: WIDTH]
m_vld  out  1  C row valid
m_rdy  in  1  C row ready
m_row  out  SIZE*WIDTH  C row
m_last  out  1  marks C row SIZE-1
o_err  out  1  sticky timeout flag
sa_we  out  1  to sa_top i_we
sa_a_vld  out  1  to sa_top i_a_vld
sa_rows  out  SIZE*WIDTH  to sa_top i_a_rows
sa_c_vld  out  1  to sa_top i_c_vld
sa_c_vld_in  in  1  from sa_top o_c_vld
sa_c_rows  in  SIZE*WIDTH  from sa_top o_c_rows

Behaviour:
- Reset values:
  - s_rdy=0, m_vld=0, m_last=0, o_err=0.
  - sa_we=0, sa_a_vld=0, sa_c_vld=0, sa_rows=0.
  - State=ALIGN, row counter=0, C buffer count=0.
- we_ptr:
  - Mod-SIZE counter, initialised to 0 at power-up and NOT cleared by rst.
  - Increments on every cycle sa_we=1, so it mirrors the write pointer inside sa_top, which has no reset.
- All sa_* outputs are registered: a handshake (s_vld&&s_rdy) in cycle n drives sa_rows and the strobe in cycle n+1, for exactly one cycle.
- States:
  - ALIGN:
    - s_rdy=0.
    - If we_ptr!=0, issue sa_we=1 with sa_rows=0 each cycle until we_ptr wraps to 0.
    - When we_ptr==0, go to LOAD_B.
  - LOAD_B:
    - s_rdy=1.
    - Each handshake produces one sa_we pulse carrying s_row.
    - After SIZE handshakes, go to LOAD_A.
    - Gaps in s_vld are allowed; no pulses are issued during gaps.
  - LOAD_A:
    - s_rdy=1.
    - Each handshake produces one sa_a_vld pulse.
    - After SIZE handshakes, go to DRAIN.
    - s_rdy drops in the cycle after the last handshake.
  - DRAIN:
    - Count DRAIN cycles, then go to REQ.
  - REQ:
    - sa_c_vld=1 for exactly SIZE consecutive cycles, then go to COLLECT.
  - COLLECT:
    - Each cycle sa_c_vld_in=1, write sa_c_rows into buffer[count] and increment count.
    - When count reaches SIZE, go to OUT.
    - Counting for TIMEOUT starts on entry to REQ.
    - If TIMEOUT cycles elapse with count<SIZE: set o_err, discard partial rows, go to IDLE_ERR.
  - OUT:
    - m_vld=1, m_row=buffer[rd], m_last=(rd==SIZE-1).
    - rd advances only on m_vld&&m_rdy.
    - m_row stays stable while m_rdy=0.
    - After the last beat, go to LOAD_B for the next job; no ALIGN is needed because we_ptr==0.
  - IDLE_ERR:
    - All outputs idle; stays here until rst.
- s_rdy=0 in every state except LOAD_B and LOAD_A; no input row is accepted while C is pending or being drained.
- sa_c_vld_in pulses outside COLLECT are ignored.
- Extra pulses after count==SIZE are ignored.
- rst mid-operation:
  - All state is cleared except we_ptr.
  - Any partial C buffer is dropped.
  - The next job starts cleanly after the ALIGN padding.
- o_err clears only on rst.

Test Plan:
- Identity check (SIZE=4, WIDTH=16): B=identity, A rows {1,2,3,4}..{13,14,15,16} -> exactly 4 sa_we pulses, then 4 sa_a_vld pulses, sa_c_vld high 4 cycles starting DRAIN cycles after last sa_a_vld; m_row beats equal the A rows in order, m_last on beat 3.
- Input gaps: s_vld toggles 1,0,0,1 across B rows -> sa_we pulses only on handshake cycles, exactly 4 total; result unchanged.
- Output backpressure: m_rdy low for 5 cycles at beat 1 -> m_vld held, m_row stable, no beat lost; s_rdy stays 0 until beat 3 is accepted.
- Reset after 2 B rows -> after rst, ALIGN issues 2 zero-data sa_we pulses (we_ptr 2->0), then LOAD_B accepts a fresh 4-row B; next job's C is correct.
- Timeout: bench never asserts sa_c_vld_in -> o_err=1 exactly TIMEOUT cycles after entering REQ, s_rdy and m_vld stay 0; rst clears o_err.
- Back-to-back jobs: two jobs with no idle between -> second job's first B row is accepted the cycle after the first job's m_last handshake; both C outputs correct.
